// File: rtl/alu_accum_pkg.sv
// alu_accum_pkg
//   Shared definitions for the accumulator controller that sits in front of
//   the 5-bit four-function ALU: opcode encodings, ALU select encodings,
//   FSM state encoding and the datapath width.
//   No ports (package).
package alu_accum_pkg;

    localparam int WIDTH_ALU = 5;

    // Command opcodes
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_READ  = 3'b111;

    // ALU function select
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_ADD = 2'b01;
    localparam logic [1:0] SEL_OR  = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Map an opcode to the ALU select; non-ALU opcodes park the select at AND.
    function automatic logic [1:0] op_to_sel(input logic [2:0] op);
        logic [1:0] sel;
        sel = SEL_AND;
        case (op)
            OP_ADD:  sel = SEL_ADD;
            OP_OR:   sel = SEL_OR;
            OP_XOR:  sel = SEL_XOR;
            default: sel = SEL_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_accum_ctrl.sv
// alu_accum_ctrl
//   Sequential initiator for the external combinational 5-bit ALU. Accepts
//   one accumulator command at a time, runs ALU ops through a one-cycle EXEC
//   state, and returns the accumulator on a response port.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high; the sender holds its payload stable while valid is high and
//   ready is low; valid never depends combinationally on ready.
//
//   Ports:
//     clk, rst_n           clock (rising edge), synchronous active-low reset
//     cmd_valid/ready      command handshake; cmd_op, cmd_data payload
//     alu_a, alu_b, alu_sel  operands/select to the ALU (alu_a = accumulator)
//     alu_out              ALU result (combinational, same cycle)
//     rsp_valid/ready      response handshake; rsp_data, rsp_ovf payload
//     dbg_state            current FSM state, for observation only
//
//   Optional build macro: ALU_ACCUM_OVF_EN enables the ADD carry-out flag on
//   rsp_ovf. Without it rsp_ovf is tied low and no carry logic exists.
import alu_accum_pkg::*;

module alu_accum_ctrl #(
    parameter int WIDTH = WIDTH_ALU
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;

`ifdef ALU_ACCUM_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_ext;

    // Carry is recomputed here rather than taken from the ALU, whose result
    // is only WIDTH bits wide.
    assign sum_ext = {1'b0, acc_q} + {1'b0, alu_b_q};
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
`ifdef ALU_ACCUM_OVF_EN
        ovf_d     = ovf_q;
`endif
        // Gated with rst_n so no command is advertised while reset is held.
        cmd_ready = rst_n && (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    alu_b_d   = cmd_data;
                    alu_sel_d = op_to_sel(cmd_op);
`ifdef ALU_ACCUM_OVF_EN
                    ovf_d     = 1'b0;
`endif
                    case (cmd_op)
                        OP_AND, OP_ADD, OP_OR, OP_XOR: state_d = ST_EXEC;
                        OP_LOAD: begin
                            acc_d   = cmd_data;
                            state_d = ST_RESP;
                        end
                        OP_CLEAR: begin
                            acc_d   = '0;
                            state_d = ST_RESP;
                        end
                        OP_READ: state_d = ST_RESP;
                        default: state_d = ST_IDLE; // NOP: consumed silently
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d   = alu_out;
                state_d = ST_RESP;
`ifdef ALU_ACCUM_OVF_EN
                ovf_d   = (alu_sel_q == SEL_ADD) ? sum_ext[WIDTH] : 1'b0;
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= SEL_AND;
`ifdef ALU_ACCUM_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
`ifdef ALU_ACCUM_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign alu_a     = acc_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = (state_q == ST_RESP);
    // acc only changes on EXEC/accept edges, so it is stable throughout RESP.
    assign rsp_data  = acc_q;
    assign dbg_state = state_q;
`ifdef ALU_ACCUM_OVF_EN
    assign rsp_ovf   = ovf_q;
`else
    assign rsp_ovf   = 1'b0;
`endif

endmodule
